// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop synchronised rx, half-bit start qualification,
// optional parity and one or two stop bits. Define RX_MAJORITY_EN for 3-sample majority voting.
module uart_rx_param #(
   parameter logic [15:0] BIT_RATE_VAL = 16'h01B0,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY_MODE  = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 res,
   input  logic                 rx,
   output logic                 take,
   output logic [DATA_BITS-1:0] dout,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned BIT_W = 4;
   localparam logic [CNT_W-1:0] HALF_LOAD = BIT_RATE_VAL >> 1;
   localparam logic [CNT_W-1:0] FULL_LOAD = BIT_RATE_VAL - 16'd1;
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
   localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_DONE
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 armed_q, armed_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic                 par_pend_q, par_pend_d;
   logic                 frm_pend_q, frm_pend_d;
   logic                 take_q, take_d;
   logic [DATA_BITS-1:0] dout_q, dout_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 busy_q, busy_d;
   logic                 rx_meta_q, rxs_q;
   logic                 sample_pt_c;
   logic                 sample_c;
   logic                 par_exp_c;

   // Two-flop synchroniser; resets to the idle-high line level
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rxs_q     <= rx_meta_q;
      end
   end

`ifdef RX_MAJORITY_EN
   // hist_q[0] holds rxs at counter==1, hist_q[1] at counter==2 when the counter hits 0
   logic [1:0] hist_q;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= {hist_q[0], rxs_q};
      end
   end

   assign sample_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
`else
   assign sample_c = rxs_q;
`endif

   assign sample_pt_c = (cnt_q == '0);
   assign par_exp_c   = (PARITY_MODE == 2) ? ~(^shift_q) : (^shift_q);

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = (cnt_q != '0) ? (cnt_q - 16'd1) : cnt_q;
      armed_d    = armed_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      par_pend_d = par_pend_q;
      frm_pend_d = frm_pend_q;
      take_d     = 1'b0;
      dout_d     = dout_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (rxs_q) begin
               armed_d = 1'b1;
            end
            if (armed_q && !rxs_q) begin
               state_d = S_START;
               cnt_d   = HALF_LOAD;
            end
         end
         S_START: begin
            if (sample_pt_c) begin
               if (sample_c) begin
                  state_d = S_IDLE;
                  armed_d = 1'b0;
                  cnt_d   = '0;
               end else begin
                  state_d    = S_DATA;
                  cnt_d      = FULL_LOAD;
                  bit_cnt_d  = '0;
                  par_pend_d = 1'b0;
                  frm_pend_d = 1'b0;
               end
            end
         end
         S_DATA: begin
            if (sample_pt_c) begin
               cnt_d     = FULL_LOAD;
               shift_d   = {sample_c, shift_q[DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == LAST_BIT) begin
                  stop_cnt_d = 1'b0;
                  state_d    = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (sample_pt_c) begin
               cnt_d   = FULL_LOAD;
               state_d = S_STOP;
               if (sample_c != par_exp_c) begin
                  par_pend_d = 1'b1;
               end
            end
         end
         S_STOP: begin
            if (sample_pt_c) begin
               cnt_d = FULL_LOAD;
               if (!sample_c) begin
                  frm_pend_d = 1'b1;
               end
               if (stop_cnt_q == LAST_STOP) begin
                  // Outputs land together with the DONE state
                  state_d = S_DONE;
                  take_d  = 1'b1;
                  dout_d  = shift_q;
                  perr_d  = (PARITY_MODE != 0) & par_pend_q;
                  ferr_d  = frm_pend_q | ~sample_c;
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            armed_d = 1'b0;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            armed_d = 1'b0;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         armed_q    <= 1'b0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         par_pend_q <= 1'b0;
         frm_pend_q <= 1'b0;
         take_q     <= 1'b0;
         dout_q     <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         armed_q    <= armed_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         par_pend_q <= par_pend_d;
         frm_pend_q <= frm_pend_d;
         take_q     <= take_d;
         dout_q     <= dout_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         busy_q     <= busy_d;
      end
   end

   assign take       = take_q;
   assign dout       = dout_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 16 clocks/bit, 8 data bits, even parity, 1 stop bit.
module tb_uart_rx_param;

   localparam int unsigned BR = 16;

   logic       clk = 1'b0;
   logic       res = 1'b0;
   logic       rx  = 1'b1;
   logic       take;
   logic [7:0] dout;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   int checks = 0;
   int errors = 0;

   int         take_cnt  = 0;
   logic [7:0] cap_dout  = 8'h00;
   logic       cap_perr  = 1'b0;
   logic       cap_ferr  = 1'b0;
   logic       busy_2    = 1'b1;
   logic [1:0] tk_hist   = 2'b00;

   uart_rx_param #(
      .BIT_RATE_VAL(16'd16),
      .DATA_BITS   (8),
      .PARITY_MODE (1),
      .STOP_BITS   (1)
   ) dut (
      .clk       (clk),
      .res       (res),
      .rx        (rx),
      .take      (take),
      .dout      (dout),
      .parity_err(parity_err),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Take monitor: counts strobes, captures payload, records busy two cycles later
   always @(negedge clk) begin
      if (take === 1'b1) begin
         take_cnt = take_cnt + 1;
         cap_dout = dout;
         cap_perr = parity_err;
         cap_ferr = frame_err;
      end
      if (tk_hist[1]) busy_2 = busy;
      tk_hist = {tk_hist[0], take};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_level(input logic v, input int n);
      repeat (n) begin
         @(negedge clk);
         rx = v;
      end
   endtask

   // One frame: start, 8 data LSB first, parity, stop; optional 1-clock inversion at each data-bit sample
   task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb, input bit glitch);
      logic [10:0] bits;
      logic        v;
      bits = {sb, pb, d, 1'b0};
      for (int j = 0; j < 11; j++) begin
         for (int k = 0; k < int'(BR); k++) begin
            v = bits[j];
            if (glitch && j >= 1 && j <= 8 && k == 9) v = ~v;
            @(negedge clk);
            rx = v;
         end
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic       pbit;
      logic       stop;
      logic [7:0] exp_dout;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int prev;
      logic [7:0] glitch_exp;

      vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
      vecs[2] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
      vecs[3] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
      vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_take", 32'(take), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_perr", 32'(parity_err), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      res = 1'b1;
      drive_level(1'b1, 8);

      // Table of well-formed and parity-error frames
      for (int i = 0; i < 6; i++) begin
         prev = take_cnt;
         send_frame(vecs[i].data, vecs[i].pbit, vecs[i].stop, 1'b0);
         drive_level(1'b1, 8);
         chk($sformatf("v%0d_takes", i), 32'(take_cnt - prev), 32'd1);
         chk($sformatf("v%0d_dout", i), 32'(cap_dout), 32'(vecs[i].exp_dout));
         chk($sformatf("v%0d_perr", i), 32'(cap_perr), 32'(vecs[i].exp_perr));
         chk($sformatf("v%0d_ferr", i), 32'(cap_ferr), 32'(vecs[i].exp_ferr));
         chk($sformatf("v%0d_busy2", i), 32'(busy_2), 32'd0);
      end

      // Stop bit 0 and line stuck low: one take, then nothing until line idles high
      prev = take_cnt;
      send_frame(8'h55, 1'b0, 1'b0, 1'b0);
      drive_level(1'b0, 40);
      chk("ferr_takes", 32'(take_cnt - prev), 32'd1);
      chk("ferr_dout", 32'(cap_dout), 32'h55);
      chk("ferr_ferr", 32'(cap_ferr), 32'd1);
      chk("ferr_perr", 32'(cap_perr), 32'd0);
      drive_level(1'b0, 60);
      chk("ferr_no_retrigger", 32'(take_cnt - prev), 32'd1);
      drive_level(1'b1, 8);
      prev = take_cnt;
      send_frame(8'h12, 1'b0, 1'b1, 1'b0);
      drive_level(1'b1, 8);
      chk("recov_takes", 32'(take_cnt - prev), 32'd1);
      chk("recov_dout", 32'(cap_dout), 32'h12);
      chk("recov_ferr", 32'(cap_ferr), 32'd0);

      // 3-clock low pulse is rejected as a false start
      prev = take_cnt;
      drive_level(1'b0, 3);
      drive_level(1'b1, 3);
      chk("pulse_busy_mid", 32'(busy), 32'd1);
      drive_level(1'b1, 7);
      chk("pulse_busy_end", 32'(busy), 32'd0);
      drive_level(1'b1, 30);
      chk("pulse_no_take", 32'(take_cnt - prev), 32'd0);

      // Reset pulse during data bit 4 of 0xF1 (remaining bits all high so nothing restarts)
      prev = take_cnt;
      drive_level(1'b0, 16);
      drive_level(1'b1, 16);
      drive_level(1'b0, 16 * 3);
      drive_level(1'b1, 8);
      @(negedge clk);
      res = 1'b0;
      #1;
      chk("mid_rst_take", 32'(take), 32'd0);
      chk("mid_rst_dout", 32'(dout), 32'd0);
      chk("mid_rst_perr", 32'(parity_err), 32'd0);
      chk("mid_rst_ferr", 32'(frame_err), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      res = 1'b1;
      drive_level(1'b1, 6 + 16 * 5 + 20);
      chk("mid_rst_no_take", 32'(take_cnt - prev), 32'd0);
      send_frame(8'h81, 1'b0, 1'b1, 1'b0);
      drive_level(1'b1, 8);
      chk("post_rst_takes", 32'(take_cnt - prev), 32'd1);
      chk("post_rst_dout", 32'(cap_dout), 32'h81);
      chk("post_rst_perr", 32'(cap_perr), 32'd0);

      // Single-clock inversion exactly at each data sample point
`ifdef RX_MAJORITY_EN
      glitch_exp = 8'hF0;
`else
      glitch_exp = 8'h0F;
`endif
      prev = take_cnt;
      send_frame(8'hF0, 1'b0, 1'b1, 1'b1);
      drive_level(1'b1, 8);
      chk("glitch_takes", 32'(take_cnt - prev), 32'd1);
      chk("glitch_dout", 32'(cap_dout), 32'(glitch_exp));
      chk("glitch_perr", 32'(cap_perr), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
